// File: rtl/sha_mainloop.sv
// sha_mainloop: SHA-256 compression of one pre-padded 512-bit block.
// Uses the FIPS 180-4 initial hash values and runs once after reset is released.
// The message schedule is produced on the fly by a 16-word sliding window, one round per clock.
// Optional debug build: define SHA_MAINLOOP_DEBUG_EN to add the round_idx and state_o outputs
// and a per-round trace in simulation.
module sha_mainloop #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] padded,
  output logic [255:0] digest,
  output logic         done
`ifdef SHA_MAINLOOP_DEBUG_EN
  ,
  output logic [6:0]   round_idx,
  output logic [2:0]   state_o
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  localparam logic [31:0] HINIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_e       state_q;
  logic [6:0]   t_q;
  logic [31:0]  a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0]  w_q [16];
  logic [255:0] digest_q;
  logic         done_q;

  logic [31:0]  bigSig0, bigSig1, chVal, majVal, kt;
  logic [31:0]  t1_d, t2_d, wNew_d;
  logic [255:0] digest_d;

  // Round datapath: T1/T2 for the current round, the next schedule word and the final digest sum.
  always_comb begin
    kt      = K[t_q[5:0]];
    bigSig0 = rotr(a_q, 2) ^ rotr(a_q, 13) ^ rotr(a_q, 22);
    bigSig1 = rotr(e_q, 6) ^ rotr(e_q, 11) ^ rotr(e_q, 25);
    chVal   = (e_q & f_q) ^ (~e_q & g_q);
    majVal  = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
    t1_d    = h_q + bigSig1 + chVal + kt + w_q[0];
    t2_d    = bigSig0 + majVal;
    wNew_d  = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10))
            + w_q[9]
            + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3))
            + w_q[0];
    digest_d = {HINIT[0] + a_q, HINIT[1] + b_q, HINIT[2] + c_q, HINIT[3] + d_q,
                HINIT[4] + e_q, HINIT[5] + f_q, HINIT[6] + g_q, HINIT[7] + h_q};
  end

  // Control FSM with working registers, schedule window and registered digest/done.
  // The edge leaving LOAD performs round 0, so rounds occupy edges 2..65 and FINAL lands on edge 66.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      t_q      <= '0;
      done_q   <= 1'b0;
      digest_q <= '0;
      a_q <= HINIT[0]; b_q <= HINIT[1]; c_q <= HINIT[2]; d_q <= HINIT[3];
      e_q <= HINIT[4]; f_q <= HINIT[5]; g_q <= HINIT[6]; h_q <= HINIT[7];
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= LOAD;
          t_q     <= '0;
          a_q <= HINIT[0]; b_q <= HINIT[1]; c_q <= HINIT[2]; d_q <= HINIT[3];
          e_q <= HINIT[4]; f_q <= HINIT[5]; g_q <= HINIT[6]; h_q <= HINIT[7];
          for (int i = 0; i < 16; i++) w_q[i] <= padded[511 - 32*i -: 32];
        end
        LOAD, ROUND: begin
          h_q <= g_q;
          g_q <= f_q;
          f_q <= e_q;
          e_q <= d_q + t1_d;
          d_q <= c_q;
          c_q <= b_q;
          b_q <= a_q;
          a_q <= t1_d + t2_d;
          for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= wNew_d;
          t_q     <= t_q + 7'd1;
          state_q <= (t_q == LAST_T) ? FINAL : ROUND;
        end
        FINAL: begin
          digest_q <= digest_d;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign digest = digest_q;
  assign done   = done_q;

`ifdef SHA_MAINLOOP_DEBUG_EN
  assign round_idx = (state_q == ROUND) ? t_q :
                     ((state_q == FINAL) || (state_q == DONE)) ? 7'd64 : 7'd0;
  assign state_o   = state_q;

`ifndef SYNTHESIS
  // Simulation trace of the working state as each round is applied.
  always_ff @(posedge clk) begin
    if (rst && ((state_q == LOAD) || (state_q == ROUND)))
      $display("[sha_mainloop] t=%0d a=%08h e=%08h", t_q, a_q, e_q);
  end
`endif
`endif

endmodule

// File: tb/tb_sha_mainloop.sv
// Self-checking bench for sha_mainloop: known vectors, random blocks against a
// reference SHA-256 model, latency, stickiness, input stability and mid-run reset.
module tb_sha_mainloop;

  localparam logic [255:0] ABC_DIGEST   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIGEST = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] ABC_BLOCK    = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLOCK  = {32'h80000000, 480'h0};

  localparam logic [31:0] REF_H [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] REF_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    string        name;
    logic [511:0] block;
    logic [255:0] expDigest;
  } vecT;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] padded;
  logic [255:0] digest;
  logic         done;
`ifdef SHA_MAINLOOP_DEBUG_EN
  logic [6:0]   round_idx;
  logic [2:0]   state_o;
`endif

  int checkCount = 0;
  int passCount  = 0;

  vecT vecs [5];

  always #5 clk = ~clk;

  sha_mainloop dut (
    .clk       (clk),
    .rst       (rst),
    .padded    (padded),
    .digest    (digest),
    .done      (done)
`ifdef SHA_MAINLOOP_DEBUG_EN
    ,
    .round_idx (round_idx),
    .state_o   (state_o)
`endif
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Whole-block SHA-256 compression: full 64-word schedule first, then 64 rounds over an array.
  function automatic logic [255:0] sha256Ref(input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2, s0, s1;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = REF_H[i];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + REF_K[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = REF_H[i] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] randomBlock();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Hold reset for two edges with the block applied, then release; the next edge is edge 1.
  task automatic applyStimulus(input logic [511:0] blk);
    rst    = 1'b0;
    padded = blk;
    tick(2);
    rst    = 1'b1;
  endtask

  initial begin
    logic [511:0] midBlk;
    logic [255:0] midExp;

    rst    = 1'b0;
    padded = '0;

    vecs[0] = '{name: "abc",   block: ABC_BLOCK,   expDigest: ABC_DIGEST};
    vecs[1] = '{name: "empty", block: EMPTY_BLOCK, expDigest: EMPTY_DIGEST};
    for (int i = 2; i < 5; i++) begin
      vecs[i].name      = $sformatf("rand%0d", i - 2);
      vecs[i].block     = randomBlock();
      vecs[i].expDigest = sha256Ref(vecs[i].block);
    end

    $display("[TB] reset state");
    tick(3);
    checkOutput("reset_done",   256'(done), 256'(1'b0));
    checkOutput("reset_digest", digest,     256'h0);

    $display("[TB] vector table");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].block);
      tick(65);
      checkOutput({vecs[v].name, "_done_e65"},   256'(done), 256'(1'b0));
      checkOutput({vecs[v].name, "_digest_e65"}, digest,     256'h0);
      tick(1);
      checkOutput({vecs[v].name, "_done_e66"},   256'(done), 256'(1'b1));
      checkOutput({vecs[v].name, "_digest_e66"}, digest,     vecs[v].expDigest);
    end

    $display("[TB] sticky done");
    applyStimulus(ABC_BLOCK);
    tick(66);
    for (int k = 0; k < 100; k++) begin
      tick(1);
      checkOutput($sformatf("sticky_done_%0d", k), 256'(done), 256'(1'b1));
      checkOutput($sformatf("sticky_dig_%0d", k),  digest,     ABC_DIGEST);
    end
    rst = 1'b0;
    tick(1);
    checkOutput("clear_done",   256'(done), 256'(1'b0));
    checkOutput("clear_digest", digest,     256'h0);

    $display("[TB] input stability");
    applyStimulus(ABC_BLOCK);
    tick(10);
    padded = '1;
    tick(56);
    checkOutput("stable_done",   256'(done), 256'(1'b1));
    checkOutput("stable_digest", digest,     ABC_DIGEST);

    $display("[TB] reset mid-run");
    midBlk = randomBlock();
    midExp = sha256Ref(midBlk);
    applyStimulus(midBlk);
    tick(30);
    rst = 1'b0;
    tick(1);
    checkOutput("mid_rst_done",   256'(done), 256'(1'b0));
    checkOutput("mid_rst_digest", digest,     256'h0);
    tick(2);
    checkOutput("mid_rst_done2",  256'(done), 256'(1'b0));
    rst = 1'b1;
    tick(65);
    checkOutput("mid_done_e65",   256'(done), 256'(1'b0));
    tick(1);
    checkOutput("mid_done_e66",   256'(done), 256'(1'b1));
    checkOutput("mid_digest_e66", digest,     midExp);

`ifdef SHA_MAINLOOP_DEBUG_EN
    $display("[TB] debug round index");
    applyStimulus(ABC_BLOCK);
    checkOutput("dbg_idle_idx", 256'(round_idx), 256'(7'd0));
    for (int k = 1; k <= 64; k++) begin
      tick(1);
      checkOutput($sformatf("dbg_idx_e%0d", k + 1), 256'(round_idx), 256'(k - 1));
    end
    tick(1);
    checkOutput("dbg_idx_final", 256'(round_idx), 256'(7'd64));
    tick(1);
    checkOutput("dbg_idx_done",   256'(round_idx), 256'(7'd64));
    checkOutput("dbg_state_done", 256'(state_o),   256'(3'd4));
    checkOutput("dbg_digest",     digest,          ABC_DIGEST);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
